// File: rtl/signed_divider_pkg.sv
// Shared constants and state encoding for the 3-bit restoring signed divider.
package signed_divider_pkg;

    localparam int W        = 3;
    localparam int STEP_CNT = 2;
    localparam int CNT_W    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/signed_divider_div_step.sv
// One combinational restoring step: shift in a dividend bit, trial-subtract |B|,
// keep the difference when non-negative, otherwise restore.
module div_step
    import signed_divider_pkg::*;
(
    input  logic [W:0] rem,
    input  logic       dvd_bit,
    input  logic [W:0] divisor,
    output logic [W:0] rem_next,
    output logic       q_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[W+1];
        rem_next = q_bit ? diff[W:0] : shifted[W:0];
    end

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed divider: magnitudes are divided by a restoring shift-subtract
// loop, then signs are applied (quotient truncates toward zero, remainder follows A).
module signed_divider
    import signed_divider_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] A,
    input  logic signed [W-1:0] B,
    output logic signed [W-1:0] Q,
    output logic signed [W-1:0] R,
    output logic                busy,
    output logic                done,
    output logic                div_zero,
    output logic                overflow
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              a_sgn, b_sgn;
    logic [W-1:0]      dq;        // dividend bits shift out the top, quotient bits shift in below
    logic [W:0]        mag_b;
    logic [W:0]        rem;
    logic [W:0]        rem_next;
    logic              q_bit;
    logic              b_zero;
    logic              neg_q;

    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] m, input logic neg);
        return neg ? (~m + 1'b1) : m;
    endfunction

    assign b_zero = (mag_b == '0);
    assign neg_q  = a_sgn ^ b_sgn;

    div_step u_div_step (
        .rem      (rem),
        .dvd_bit  (dq[W-1]),
        .divisor  (mag_b),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = DIVIDE;
            end
            DIVIDE: begin
                busy = 1'b1;
                if (b_zero)          state_next = DONE;
                else if (cnt == '0)  state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sgn    <= 1'b0;
            b_sgn    <= 1'b0;
            dq       <= '0;
            mag_b    <= '0;
            rem      <= '0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sgn <= A[W-1];
                        b_sgn <= B[W-1];
                        dq    <= mag(A);
                        mag_b <= {1'b0, mag(B)};
                        rem   <= '0;
                        cnt   <= CNT_W'(STEP_CNT);
                    end
                end
                DIVIDE: begin
                    if (b_zero) begin
                        // dq still holds |A| here, so re-signing it reproduces A
                        Q        <= '0;
                        R        <= apply_sign(dq, a_sgn);
                        div_zero <= 1'b1;
                        overflow <= 1'b0;
                    end else begin
                        rem <= rem_next;
                        dq  <= {dq[W-2:0], q_bit};
                        if (cnt != '0) cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    // Only -4 / -1 yields a positive magnitude of 4, which wraps
                    Q        <= apply_sign(dq, neg_q);
                    R        <= apply_sign(rem[W-1:0], a_sgn);
                    overflow <= (dq == {1'b1, {(W-1){1'b0}}}) && !neg_q;
                    div_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider with hand-computed quotient/remainder vectors.
module tb_signed_divider;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic signed [2:0] A;
    logic signed [2:0] B;
    logic signed [2:0] Q;
    logic signed [2:0] R;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic              overflow;

    int tests_run;
    int tests_failed;

    signed_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one division over a fixed 8-edge window after the start sample and
    // records the first done pulse. With repulse, start is raised again in DIVIDE.
    task automatic run_div(input logic [2:0] a, input logic [2:0] b, input bit repulse,
                           output logic [2:0] q, output logic [2:0] r,
                           output logic ov, output logic dz,
                           output int lat, output int busy_n, output int done_n);
        q = 'x; r = 'x; ov = 1'bx; dz = 1'bx;
        lat = -1; busy_n = 0; done_n = 0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a; B = ~b;
        if (busy) busy_n++;
        for (int i = 1; i <= 8; i++) begin
            if (repulse && i == 1) begin
                start = 1'b1; A = 3'b111; B = 3'b001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = i; q = Q; r = R; ov = overflow; dz = div_zero;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        #1;
        tests_run++; if (Q !== 3'b000)     begin tests_failed++; $display("FAIL reset_q: got %b want 000", Q); end
        tests_run++; if (R !== 3'b000)     begin tests_failed++; $display("FAIL reset_r: got %b want 000", R); end
        tests_run++; if (busy !== 1'b0)    begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0)    begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dz: got %b want 0", div_zero); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ov: got %b want 0", overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [2:0] q, r; logic ov, dz; int lat, bn, dn;
        run_div(3'b011, 3'b010, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (lat !== 4)      begin tests_failed++; $display("FAIL basic_latency: got %0d want 4", lat); end
        tests_run++; if (bn !== 4)       begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d want 4", bn); end
        tests_run++; if (dn !== 1)       begin tests_failed++; $display("FAIL basic_done_pulses: got %0d want 1", dn); end
        tests_run++; if (q !== 3'b001)   begin tests_failed++; $display("FAIL basic_q: got %b want 001", q); end
        tests_run++; if (r !== 3'b001)   begin tests_failed++; $display("FAIL basic_r: got %b want 001", r); end
        tests_run++; if (ov !== 1'b0)    begin tests_failed++; $display("FAIL basic_ov: got %b want 0", ov); end
        tests_run++; if (dz !== 1'b0)    begin tests_failed++; $display("FAIL basic_dz: got %b want 0", dz); end
        tests_run++; if (Q !== 3'b001)   begin tests_failed++; $display("FAIL basic_q_hold: got %b want 001", Q); end
    endtask

    task automatic test_signs();
        logic [2:0] q, r; logic ov, dz; int lat, bn, dn;
        // -3 / 2 = -1 rem -1
        run_div(3'b101, 3'b010, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (q !== 3'b111) begin tests_failed++; $display("FAIL neg_a_q: got %b want 111", q); end
        tests_run++; if (r !== 3'b111) begin tests_failed++; $display("FAIL neg_a_r: got %b want 111", r); end
        // 3 / -2 = -1 rem 1
        run_div(3'b011, 3'b110, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (q !== 3'b111) begin tests_failed++; $display("FAIL neg_b_q: got %b want 111", q); end
        tests_run++; if (r !== 3'b001) begin tests_failed++; $display("FAIL neg_b_r: got %b want 001", r); end
        // -2 / -3 = 0 rem -2
        run_div(3'b110, 3'b101, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (q !== 3'b000) begin tests_failed++; $display("FAIL both_neg_q: got %b want 000", q); end
        tests_run++; if (r !== 3'b110) begin tests_failed++; $display("FAIL both_neg_r: got %b want 110", r); end
        // -4 / 3 = -1 rem -1
        run_div(3'b100, 3'b011, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (q !== 3'b111) begin tests_failed++; $display("FAIL min_a_q: got %b want 111", q); end
        tests_run++; if (r !== 3'b111) begin tests_failed++; $display("FAIL min_a_r: got %b want 111", r); end
    endtask

    task automatic test_overflow();
        logic [2:0] q, r; logic ov, dz; int lat, bn, dn;
        run_div(3'b100, 3'b111, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (q !== 3'b100) begin tests_failed++; $display("FAIL ovf_q: got %b want 100", q); end
        tests_run++; if (r !== 3'b000) begin tests_failed++; $display("FAIL ovf_r: got %b want 000", r); end
        tests_run++; if (ov !== 1'b1)  begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", ov); end
        tests_run++; if (dz !== 1'b0)  begin tests_failed++; $display("FAIL ovf_dz: got %b want 0", dz); end
        run_div(3'b100, 3'b001, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (q !== 3'b100) begin tests_failed++; $display("FAIL min_by_one_q: got %b want 100", q); end
        tests_run++; if (r !== 3'b000) begin tests_failed++; $display("FAIL min_by_one_r: got %b want 000", r); end
        tests_run++; if (ov !== 1'b0)  begin tests_failed++; $display("FAIL min_by_one_ov: got %b want 0", ov); end
    endtask

    task automatic test_div_zero();
        logic [2:0] q, r; logic ov, dz; int lat, bn, dn;
        run_div(3'b010, 3'b000, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (lat !== 1)    begin tests_failed++; $display("FAIL dz_latency: got %0d want 1", lat); end
        tests_run++; if (bn !== 1)     begin tests_failed++; $display("FAIL dz_busy_cycles: got %0d want 1", bn); end
        tests_run++; if (dn !== 1)     begin tests_failed++; $display("FAIL dz_done_pulses: got %0d want 1", dn); end
        tests_run++; if (q !== 3'b000) begin tests_failed++; $display("FAIL dz_q: got %b want 000", q); end
        tests_run++; if (r !== 3'b010) begin tests_failed++; $display("FAIL dz_r: got %b want 010", r); end
        tests_run++; if (dz !== 1'b1)  begin tests_failed++; $display("FAIL dz_flag: got %b want 1", dz); end
        tests_run++; if (ov !== 1'b0)  begin tests_failed++; $display("FAIL dz_ov: got %b want 0", ov); end
        run_div(3'b011, 3'b001, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (dz !== 1'b0)  begin tests_failed++; $display("FAIL dz_cleared: got %b want 0", dz); end
        tests_run++; if (q !== 3'b011) begin tests_failed++; $display("FAIL after_dz_q: got %b want 011", q); end
    endtask

    task automatic test_ignore_start();
        logic [2:0] q, r; logic ov, dz; int lat, bn, dn;
        run_div(3'b011, 3'b010, 1'b1, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (lat !== 4)    begin tests_failed++; $display("FAIL ignore_latency: got %0d want 4", lat); end
        tests_run++; if (dn !== 1)     begin tests_failed++; $display("FAIL ignore_done_pulses: got %0d want 1", dn); end
        tests_run++; if (q !== 3'b001) begin tests_failed++; $display("FAIL ignore_q: got %b want 001", q); end
        tests_run++; if (r !== 3'b001) begin tests_failed++; $display("FAIL ignore_r: got %b want 001", r); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] q, r; logic ov, dz; int lat, bn, dn;
        int seen_done;
        // Leave nonzero R and div_zero behind so the reset has something to clear
        run_div(3'b010, 3'b000, 1'b0, q, r, ov, dz, lat, bn, dn);
        seen_done = 0;
        @(negedge clk);
        A = 3'b011; B = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++; if (Q !== 3'b000)      begin tests_failed++; $display("FAIL midrst_q: got %b want 000", Q); end
        tests_run++; if (R !== 3'b000)      begin tests_failed++; $display("FAIL midrst_r: got %b want 000", R); end
        tests_run++; if (busy !== 1'b0)     begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy); end
        tests_run++; if (div_zero !== 1'b0) begin tests_failed++; $display("FAIL midrst_dz: got %b want 0", div_zero); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL midrst_ov: got %b want 0", overflow); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        tests_run++; if (seen_done !== 0) begin tests_failed++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen_done); end
        run_div(3'b011, 3'b001, 1'b0, q, r, ov, dz, lat, bn, dn);
        tests_run++; if (lat !== 4)    begin tests_failed++; $display("FAIL fresh_latency: got %0d want 4", lat); end
        tests_run++; if (q !== 3'b011) begin tests_failed++; $display("FAIL fresh_q: got %b want 011", q); end
        tests_run++; if (r !== 3'b000) begin tests_failed++; $display("FAIL fresh_r: got %b want 000", r); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
